// File: rtl/osc_cmd_pkg.sv
// Command codes, unit indices, scheduler states and status display codes shared by the
// oscilloscope command scheduler and its port mux.
package osc_cmd_pkg;

  localparam logic [7:0] CMD_SAMPLER     = 8'h21;
  localparam logic [7:0] CMD_SAMPLE_READ = 8'h22;
  localparam logic [7:0] CMD_MEM_CLEAR   = 8'h23;
  localparam logic [7:0] CMD_REPLAYER    = 8'h71;
  localparam logic [7:0] CMD_REPLY_CNT   = 8'h72;

  localparam int UNIT_SAMPLER     = 0;
  localparam int UNIT_SAMPLE_READ = 1;
  localparam int UNIT_MEM_CLEAR   = 2;
  localparam int UNIT_REPLAYER    = 3;
  localparam int UNIT_REPLY_CNT   = 4;

  // Wide enough for up to 8 units.
  localparam int UNIT_IDX_W = 3;
  typedef logic [UNIT_IDX_W-1:0] unit_idx_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, NAK} op_state_t;

  typedef struct packed {
    logic      hit;
    unit_idx_t idx;
  } cmd_dec_t;

  localparam logic [7:0] ST_IDLE  = 8'h00;
  localparam logic [7:0] ST_DRAIN = 8'h01;
  localparam logic [7:0] ST_NAK   = 8'hEE;

  function automatic cmd_dec_t cmd_to_unit(input logic [7:0] cmd);
    cmd_dec_t d;
    d.hit = 1'b1;
    d.idx = '0;
    case (cmd)
      CMD_SAMPLER:     d.idx = unit_idx_t'(UNIT_SAMPLER);
      CMD_SAMPLE_READ: d.idx = unit_idx_t'(UNIT_SAMPLE_READ);
      CMD_MEM_CLEAR:   d.idx = unit_idx_t'(UNIT_MEM_CLEAR);
      CMD_REPLAYER:    d.idx = unit_idx_t'(UNIT_REPLAYER);
      CMD_REPLY_CNT:   d.idx = unit_idx_t'(UNIT_REPLY_CNT);
      default:         d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/op_scheduler_if.sv
// UART, function-unit and sample-memory signals between the scheduler (master) and the
// surrounding units/peripherals (slave).
interface op_scheduler_if #(
  parameter int N_UNITS = 5,
  parameter int DW      = 8,
  parameter int AW      = 8
);
  logic                    rx_ready;
  logic [7:0]              rx_data;
  logic                    tx_active;
  logic [7:0]              tx_data;
  logic                    tx_start;
  logic [N_UNITS-1:0]      unit_activate;
  logic [N_UNITS-1:0]      unit_done;
  logic [N_UNITS*8-1:0]    unit_tx_data;
  logic [N_UNITS-1:0]      unit_tx_start;
  logic [N_UNITS-1:0]      unit_mem_we;
  logic [N_UNITS-1:0]      unit_mem_oe;
  logic [N_UNITS*AW-1:0]   unit_mem_addr_in;
  logic [N_UNITS*AW-1:0]   unit_mem_addr_out;
  logic [N_UNITS*DW-1:0]   unit_mem_data;
  logic                    mem_we;
  logic                    mem_oe;
  logic [AW-1:0]           mem_addr_in;
  logic [AW-1:0]           mem_addr_out;
  logic [DW-1:0]           mem_data_in;

  modport master (
    input  rx_ready, rx_data, tx_active, unit_done, unit_tx_data, unit_tx_start,
           unit_mem_we, unit_mem_oe, unit_mem_addr_in, unit_mem_addr_out, unit_mem_data,
    output tx_data, tx_start, unit_activate, mem_we, mem_oe, mem_addr_in, mem_addr_out,
           mem_data_in
  );

  modport slave (
    output rx_ready, rx_data, tx_active, unit_done, unit_tx_data, unit_tx_start,
           unit_mem_we, unit_mem_oe, unit_mem_addr_in, unit_mem_addr_out, unit_mem_data,
    input  tx_data, tx_start, unit_activate, mem_we, mem_oe, mem_addr_in, mem_addr_out,
           mem_data_in
  );
endinterface

// File: rtl/unit_port_mux.sv
// Combinational selection of one unit's UART TX and sample-memory signals; all outputs are
// zero while en is low, so strobes never leak outside the owning unit's run window.
module unit_port_mux #(
  parameter int N_UNITS = 5,
  parameter int DW      = 8,
  parameter int AW      = 8,
  parameter int SEL_W   = 3
) (
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_UNITS*8-1:0]  unit_tx_data,
  input  logic [N_UNITS-1:0]    unit_tx_start,
  input  logic [N_UNITS-1:0]    unit_mem_we,
  input  logic [N_UNITS-1:0]    unit_mem_oe,
  input  logic [N_UNITS*AW-1:0] unit_mem_addr_in,
  input  logic [N_UNITS*AW-1:0] unit_mem_addr_out,
  input  logic [N_UNITS*DW-1:0] unit_mem_data,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [AW-1:0]         mem_addr_in,
  output logic [AW-1:0]         mem_addr_out,
  output logic [DW-1:0]         mem_data_in
);

  always_comb begin
    tx_data      = '0;
    tx_start     = 1'b0;
    mem_we       = 1'b0;
    mem_oe       = 1'b0;
    mem_addr_in  = '0;
    mem_addr_out = '0;
    mem_data_in  = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (en && (sel == SEL_W'(i))) begin
        tx_data      = unit_tx_data[i*8 +: 8];
        tx_start     = unit_tx_start[i];
        mem_we       = unit_mem_we[i];
        mem_oe       = unit_mem_oe[i];
        mem_addr_in  = unit_mem_addr_in[i*AW +: AW];
        mem_addr_out = unit_mem_addr_out[i*AW +: AW];
        mem_data_in  = unit_mem_data[i*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/op_scheduler.sv
// Command scheduler: decodes a UART command, hands the UART TX and sample memory to one
// function unit until it reports done. OP_TIMEOUT_EN adds a RUN watchdog and sticky err.
module op_scheduler
  import osc_cmd_pkg::*;
#(
  parameter int         N_UNITS        = 5,
  parameter int         DW             = 8,
  parameter int         AW             = 8,
  parameter logic [7:0] NAK_BYTE       = 8'h15,
  parameter int         TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             clk_50mhz,
  input  logic             reset,
  op_scheduler_if.master   bus,
  output logic [7:0]       cur_state,
  output logic             busy,
  output logic             err
);

  op_state_t          state_q, state_d;
  unit_idx_t          sel_q, sel_d;
  logic [N_UNITS-1:0] act_q, act_d;
  logic [7:0]         cur_state_q, cur_state_d;
  logic               err_q, err_d;
  cmd_dec_t           dec;
  logic [7:0]         mux_tx_data;
  logic               mux_tx_start;

`ifdef OP_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    dec         = cmd_to_unit(bus.rx_data);
    state_d     = state_q;
    sel_d       = sel_q;
    act_d       = act_q;
    cur_state_d = cur_state_q;
    err_d       = err_q;
`ifdef OP_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.rx_ready) begin
          if (dec.hit) begin
            sel_d       = dec.idx;
            act_d       = N_UNITS'(1) << dec.idx;
            cur_state_d = bus.rx_data;
            err_d       = 1'b0;
            state_d     = RUN;
`ifdef OP_TIMEOUT_EN
            tmo_cnt_d   = '0;
`endif
          end else begin
            cur_state_d = ST_NAK;
            state_d     = NAK;
          end
        end
      end
      RUN: begin
        // Completion wins over a watchdog expiry landing in the same cycle.
        if (bus.unit_done[sel_q]) begin
          act_d       = '0;
          cur_state_d = ST_DRAIN;
          state_d     = DRAIN;
        end
`ifdef OP_TIMEOUT_EN
        else if (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          act_d       = '0;
          err_d       = 1'b1;
          cur_state_d = ST_NAK;
          state_d     = NAK;
        end else begin
          tmo_cnt_d   = tmo_cnt_q + 32'd1;
        end
`endif
      end
      DRAIN: begin
        if (!bus.rx_ready && !bus.tx_active) begin
          cur_state_d = ST_IDLE;
          state_d     = IDLE;
        end
      end
      NAK: begin
        if (!bus.tx_active) begin
          cur_state_d = ST_DRAIN;
          state_d     = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      act_q       <= '0;
      cur_state_q <= ST_IDLE;
      err_q       <= 1'b0;
`ifdef OP_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      act_q       <= act_d;
      cur_state_q <= cur_state_d;
      err_q       <= err_d;
`ifdef OP_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  unit_port_mux #(
    .N_UNITS (N_UNITS),
    .DW      (DW),
    .AW      (AW),
    .SEL_W   (UNIT_IDX_W)
  ) u_mux (
    .en                (state_q == RUN),
    .sel               (sel_q),
    .unit_tx_data      (bus.unit_tx_data),
    .unit_tx_start     (bus.unit_tx_start),
    .unit_mem_we       (bus.unit_mem_we),
    .unit_mem_oe       (bus.unit_mem_oe),
    .unit_mem_addr_in  (bus.unit_mem_addr_in),
    .unit_mem_addr_out (bus.unit_mem_addr_out),
    .unit_mem_data     (bus.unit_mem_data),
    .tx_data           (mux_tx_data),
    .tx_start          (mux_tx_start),
    .mem_we            (bus.mem_we),
    .mem_oe            (bus.mem_oe),
    .mem_addr_in       (bus.mem_addr_in),
    .mem_addr_out      (bus.mem_addr_out),
    .mem_data_in       (bus.mem_data_in)
  );

  // The NAK strobe fires in the first cycle the UART is free, which also leaves NAK.
  assign bus.tx_data       = (state_q == NAK) ? NAK_BYTE : mux_tx_data;
  assign bus.tx_start      = ((state_q == NAK) && !bus.tx_active) || mux_tx_start;
  assign bus.unit_activate = act_q;
  assign cur_state         = cur_state_q;
  assign busy              = (state_q != IDLE);
  assign err               = err_q;

endmodule
